// File: rtl/rv_dmem_ctrl.sv
// rv_dmem_ctrl -- data-memory access controller for the MEM stage.
//
// Takes one load/store request from the pipeline, presents it on a
// valid/ready memory request channel, waits for the read response (loads
// only) and signals completion with a one-cycle done_o pulse. A cycle
// counter aborts an access that spends TIMEOUT cycles in REQ+RSP; the abort
// completes with err_o and a zeroed rd_data_o.
//
// Ports
//   clk_i, rst_i            clock, asynchronous active-high reset
//   req_i, we_i             access request (held until done_o), 1 = store
//   funct3_i                access size in [1:0]: byte/half/word/dword
//   addr_i                  byte address (dword-aligned on the bus)
//   wr_strobe_i, wr_data_i  byte-lane strobe and right-justified store data
//   rd_data_o               raw 64-bit dword from the last load
//   stall_o, done_o, err_o  pipeline hold, completion pulse, timeout pulse
//   mem_valid_o/mem_ready_i request handshake
//   mem_we_o, mem_addr_o, mem_wstrb_o, mem_wdata_o  request payload
//   mem_rvalid_i, mem_rdata_i                        read response
module rv_dmem_ctrl #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_i,
  input  logic        we_i,
  input  logic [2:0]  funct3_i,
  input  logic [63:0] addr_i,
  input  logic [7:0]  wr_strobe_i,
  input  logic [63:0] wr_data_i,
  output logic [63:0] rd_data_o,
  output logic        stall_o,
  output logic        done_o,
  output logic        err_o,
  output logic        mem_valid_o,
  input  logic        mem_ready_i,
  output logic        mem_we_o,
  output logic [63:0] mem_addr_o,
  output logic [7:0]  mem_wstrb_o,
  output logic [63:0] mem_wdata_o,
  input  logic        mem_rvalid_i,
  input  logic [63:0] mem_rdata_i
);

  typedef enum logic [1:0] {IDLE, REQ, RSP, DONE} state_t;

  // Counter value seen in the TIMEOUT-th cycle spent in REQ+RSP.
  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  state_t      state_q, state_d;
  logic [7:0]  cnt_q,   cnt_d;
  logic        we_q,    we_d;
  logic [63:0] addr_q,  addr_d;
  logic [7:0]  wstrb_q, wstrb_d;
  logic [63:0] wdata_q, wdata_d;
  logic [63:0] rdata_q, rdata_d;
  logic        err_q,   err_d;
  logic        timeout_hit;

  // Low address bits and funct3[2] (signedness) belong to the lane mapper.
  logic unused_ok;
  assign unused_ok = ^{addr_i[2:0], funct3_i[2]};

  // Copy the right-justified store data into every lane of its size so the
  // byte strobe alone selects where it lands.
  function automatic logic [63:0] replicate(input logic [1:0] sz,
                                            input logic [63:0] d);
    logic [63:0] r;
    case (sz)
      2'b00:   r = {8{d[7:0]}};
      2'b01:   r = {4{d[15:0]}};
      2'b10:   r = {2{d[31:0]}};
      default: r = d;
    endcase
    return r;
  endfunction

  assign timeout_hit = (cnt_q == CNT_LAST);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wstrb_d = wstrb_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (req_i) begin
          state_d = REQ;
          we_d    = we_i;
          addr_d  = {addr_i[63:3], 3'b000};
          wstrb_d = we_i ? wr_strobe_i : 8'h00;
          wdata_d = replicate(funct3_i[1:0], wr_data_i);
          cnt_d   = 8'd0;
          err_d   = 1'b0;
        end
      end
      REQ: begin
        cnt_d = cnt_q + 8'd1;
        // A handshake in the last allowed cycle still counts as success.
        if (mem_ready_i) begin
          state_d = we_q ? DONE : RSP;
        end else if (timeout_hit) begin
          state_d = DONE;
          err_d   = 1'b1;
          rdata_d = 64'd0;
        end
      end
      RSP: begin
        cnt_d = cnt_q + 8'd1;
        if (mem_rvalid_i) begin
          state_d = DONE;
          rdata_d = mem_rdata_i;
        end else if (timeout_hit) begin
          state_d = DONE;
          err_d   = 1'b1;
          rdata_d = 64'd0;
        end
      end
      default: begin
        state_d = IDLE;
        err_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      cnt_q   <= 8'd0;
      we_q    <= 1'b0;
      addr_q  <= 64'd0;
      wstrb_q <= 8'h00;
      wdata_q <= 64'd0;
      rdata_q <= 64'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wstrb_q <= wstrb_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // Decoded straight from the state register, so reset drops them at once.
  assign mem_valid_o = (state_q == REQ);
  assign done_o      = (state_q == DONE);
  assign err_o       = (state_q == DONE) & err_q;
  assign stall_o     = ((state_q == IDLE) & req_i) | (state_q == REQ) |
                       (state_q == RSP);
  assign mem_we_o    = we_q;
  assign mem_addr_o  = addr_q;
  assign mem_wstrb_o = wstrb_q;
  assign mem_wdata_o = wdata_q;
  assign rd_data_o   = rdata_q;

endmodule

// File: tb/tb_rv_dmem_ctrl.sv
// Bench for rv_dmem_ctrl: two instances (default TIMEOUT and TIMEOUT=4)
// share all inputs except req. Directed vectors push expected bus requests
// and completions into queues; a negedge monitor compares them whenever an
// instance presents mem_valid_o or done_o.
module tb_rv_dmem_ctrl;

  logic        clk = 1'b0;
  logic        rst, req, req2, we, mready, mrvalid;
  logic [2:0]  f3;
  logic [63:0] addr, wdata, mrdata;
  logic [7:0]  strb;

  logic [63:0] rd, maddr, mwdata, t_rd, t_maddr, t_mwdata;
  logic        stall, done, err, mvalid, mwe;
  logic        t_stall, t_done, t_err, t_mvalid, t_mwe;
  logic [7:0]  mwstrb, t_mwstrb;

  typedef struct packed {
    logic        we;
    logic [63:0] addr;
    logic [7:0]  wstrb;
    logic [63:0] wdata;
  } mem_t;
  typedef struct packed {
    logic        err;
    logic [63:0] rd;
  } rsp_t;

  mem_t mq[$];
  rsp_t rq[$];
  int   n_vec  = 0;
  int   n_miss = 0;

  always #5 clk = ~clk;

  rv_dmem_ctrl u_dut (
    .clk_i(clk), .rst_i(rst), .req_i(req), .we_i(we), .funct3_i(f3),
    .addr_i(addr), .wr_strobe_i(strb), .wr_data_i(wdata), .rd_data_o(rd),
    .stall_o(stall), .done_o(done), .err_o(err), .mem_valid_o(mvalid),
    .mem_ready_i(mready), .mem_we_o(mwe), .mem_addr_o(maddr),
    .mem_wstrb_o(mwstrb), .mem_wdata_o(mwdata), .mem_rvalid_i(mrvalid),
    .mem_rdata_i(mrdata)
  );

  rv_dmem_ctrl #(.TIMEOUT(4)) u_to (
    .clk_i(clk), .rst_i(rst), .req_i(req2), .we_i(we), .funct3_i(f3),
    .addr_i(addr), .wr_strobe_i(strb), .wr_data_i(wdata), .rd_data_o(t_rd),
    .stall_o(t_stall), .done_o(t_done), .err_o(t_err), .mem_valid_o(t_mvalid),
    .mem_ready_i(mready), .mem_we_o(t_mwe), .mem_addr_o(t_maddr),
    .mem_wstrb_o(t_mwstrb), .mem_wdata_o(t_mwdata), .mem_rvalid_i(mrvalid),
    .mem_rdata_i(mrdata)
  );

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h, required %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic mon_mem(input string nm, input logic w, input logic [63:0] a,
                         input logic [7:0] s, input logic [63:0] d,
                         input logic rdy);
    mem_t e;
    if (mq.size() == 0) begin
      n_vec++;
      n_miss++;
      $display("FAIL %s_unexpected_valid: got mem_valid_o=1, required 0", nm);
    end else begin
      e = mq[0];
      chk({nm, "_we"},    64'(w), 64'(e.we));
      chk({nm, "_addr"},  a,      e.addr);
      chk({nm, "_wstrb"}, 64'(s), 64'(e.wstrb));
      chk({nm, "_wdata"}, d,      e.wdata);
      if (rdy) void'(mq.pop_front());
    end
  endtask

  task automatic mon_done(input string nm, input logic e_o,
                          input logic [63:0] r);
    rsp_t e;
    if (rq.size() == 0) begin
      n_vec++;
      n_miss++;
      $display("FAIL %s_unexpected_done: got done_o=1, required 0", nm);
    end else begin
      e = rq.pop_front();
      chk({nm, "_err"},     64'(e_o), 64'(e.err));
      chk({nm, "_rd_data"}, r,        e.rd);
    end
  endtask

  // Monitor: compares whenever an instance presents a request or completion.
  always @(negedge clk) begin
    if (mvalid)   mon_mem("m", mwe, maddr, mwstrb, mwdata, mready);
    if (t_mvalid) mon_mem("t", t_mwe, t_maddr, t_mwstrb, t_mwdata, mready);
    if (done)     mon_done("m", err, rd);
    if (t_done)   mon_done("t", t_err, t_rd);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Entered at posedge+1 of an IDLE cycle (cycle 0); returns at the negedge
  // of the DONE cycle. Acts as the memory: ready after rdy_dly valid cycles,
  // rvalid rv_dly cycles after the handshake.
  task automatic do_access(input bit sel, input logic w, input logic [2:0] fn,
                           input logic [63:0] a, input logic [7:0] s,
                           input logic [63:0] d, input int rdy_dly,
                           input int rv_dly, input logic [63:0] rdat,
                           input mem_t em, input rsp_t er, input int exp_lat,
                           input bit hs_exp, input bit noise);
    int   cyc  = 0;
    int   hs   = -1;
    int   vcnt = 0;
    bit   fin  = 0;
    logic v;
    mq.push_back(em);
    rq.push_back(er);
    we = w; f3 = fn; addr = a; strb = s; wdata = d;
    if (sel) req2 = 1'b1; else req = 1'b1;
    while (!fin && cyc < 40) begin
      v      = sel ? t_mvalid : mvalid;
      mready = v && (vcnt >= rdy_dly);
      if (v) vcnt++;
      if (hs >= 0 && cyc == hs + rv_dly) begin
        mrvalid = 1'b1; mrdata = rdat;
      end else if (noise && hs < 0) begin
        mrvalid = 1'b1; mrdata = 64'hBAD0_BAD0_BAD0_BAD0;
      end else begin
        mrvalid = 1'b0; mrdata = 64'd0;
      end
      if (mready) hs = cyc;
      if (cyc == 1) chk("valid_cycle1", 64'(v), 64'd1);
      @(negedge clk);
      if (sel ? t_done : done) fin = 1;
      else chk("stall_busy", 64'(sel ? t_stall : stall), 64'd1);
      if (!fin) begin
        @(posedge clk);
        #1;
        cyc++;
      end
    end
    if (!fin) begin
      n_vec++;
      n_miss++;
      $display("FAIL access_timeout: got no done_o in %0d cycles, required %0d",
               cyc, exp_lat);
      mq.delete();
      rq.delete();
    end else begin
      chk("latency",      64'(cyc), 64'(exp_lat));
      chk("stall_done",   64'(sel ? t_stall : stall), 64'd0);
      chk("valid_done",   64'(sel ? t_mvalid : mvalid), 64'd0);
      chk("handshake",    64'(hs >= 0), 64'(hs_exp));
      if (!hs_exp && mq.size() > 0) void'(mq.pop_front());
    end
    req = 1'b0; req2 = 1'b0; mready = 1'b0; mrvalid = 1'b0; mrdata = 64'd0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no end of test, required $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; req = 1'b0; req2 = 1'b0; we = 1'b0; f3 = 3'd0; addr = 64'd0;
    strb = 8'h00; wdata = 64'd0; mready = 1'b0; mrvalid = 1'b0;
    mrdata = 64'd0;
    step(); step();
    // Reset state
    chk("rst_rd_data", rd, 64'd0);
    chk("rst_stall",   64'(stall), 64'd0);
    chk("rst_done",    64'(done), 64'd0);
    chk("rst_err",     64'(err), 64'd0);
    chk("rst_valid",   64'(mvalid), 64'd0);
    chk("rst_addr",    maddr, 64'd0);
    chk("rst_wdata",   mwdata, 64'd0);
    chk("rst_wstrb",   64'(mwstrb), 64'd0);
    req = 1'b1;
    #1 chk("rst_stall_follows_req", 64'(stall), 64'd1);
    req = 1'b0;
    step();
    rst = 1'b0;
    step();

    // Store byte, immediate ready
    do_access(0, 1, 3'd0, 64'h1003, 8'h08, 64'hAB, 0, 0, 64'd0,
              mem_t'{1'b1, 64'h1000, 8'h08, 64'hABAB_ABAB_ABAB_ABAB},
              rsp_t'{1'b0, 64'd0}, 2, 1, 0);
    step(); step();
    // Load dword, ready after 3 valid cycles, rvalid 2 later, rvalid noise
    do_access(0, 0, 3'd3, 64'h2000, 8'hFF, 64'd0, 3, 2, 64'h0123_4567_89AB_CDEF,
              mem_t'{1'b0, 64'h2000, 8'h00, 64'd0},
              rsp_t'{1'b0, 64'h0123_4567_89AB_CDEF}, 7, 1, 1);
    step(); step();
    chk("rd_hold_idle", rd, 64'h0123_4567_89AB_CDEF);
    // Store half, ready delayed 2 cycles (stability checked every valid cycle)
    do_access(0, 1, 3'd1, 64'h4, 8'h30, 64'hBEEF, 2, 0, 64'd0,
              mem_t'{1'b1, 64'h0, 8'h30, 64'hBEEF_BEEF_BEEF_BEEF},
              rsp_t'{1'b0, 64'h0123_4567_89AB_CDEF}, 4, 1, 0);
    step(); step();
    // Store word
    do_access(0, 1, 3'd2, 64'h10C, 8'hF0, 64'h1234_5678, 0, 0, 64'd0,
              mem_t'{1'b1, 64'h108, 8'hF0, 64'h1234_5678_1234_5678},
              rsp_t'{1'b0, 64'h0123_4567_89AB_CDEF}, 2, 1, 0);
    step(); step();
    // Store byte with junk above the byte
    do_access(0, 1, 3'd0, 64'h7, 8'h80, 64'hFFFF_FFFF_FFFF_FF5A, 0, 0, 64'd0,
              mem_t'{1'b1, 64'h0, 8'h80, 64'h5A5A_5A5A_5A5A_5A5A},
              rsp_t'{1'b0, 64'h0123_4567_89AB_CDEF}, 2, 1, 0);
    step(); step();
    // Store dword
    do_access(0, 1, 3'd3, 64'h30, 8'hFF, 64'hCAFE_F00D_DEAD_BEEF, 1, 0, 64'd0,
              mem_t'{1'b1, 64'h30, 8'hFF, 64'hCAFE_F00D_DEAD_BEEF},
              rsp_t'{1'b0, 64'h0123_4567_89AB_CDEF}, 3, 1, 0);
    step(); step();
    // Back-to-back loads: second req in the cycle right after DONE
    do_access(0, 0, 3'd2, 64'h48, 8'h0F, 64'd0, 0, 1, 64'h1111_2222_3333_4444,
              mem_t'{1'b0, 64'h48, 8'h00, 64'd0},
              rsp_t'{1'b0, 64'h1111_2222_3333_4444}, 3, 1, 0);
    step();
    do_access(0, 0, 3'd3, 64'h50, 8'hFF, 64'd0, 0, 1, 64'h5555_6666_7777_8888,
              mem_t'{1'b0, 64'h50, 8'h00, 64'd0},
              rsp_t'{1'b0, 64'h5555_6666_7777_8888}, 3, 1, 0);
    step(); step();

    // TIMEOUT=4 instance: good load first, then a load that never gets ready
    do_access(1, 0, 3'd3, 64'h80, 8'hFF, 64'd0, 0, 1, 64'hA5A5_A5A5_A5A5_A5A5,
              mem_t'{1'b0, 64'h80, 8'h00, 64'd0},
              rsp_t'{1'b0, 64'hA5A5_A5A5_A5A5_A5A5}, 3, 1, 0);
    step(); step();
    do_access(1, 0, 3'd3, 64'h8C, 8'hFF, 64'd0, 99, 1, 64'd0,
              mem_t'{1'b0, 64'h88, 8'h00, 64'd0},
              rsp_t'{1'b1, 64'd0}, 5, 0, 0);
    step(); step();
    chk("t_err_one_cycle", 64'(t_err), 64'd0);

    // Reset while in RSP
    mq.push_back(mem_t'{1'b0, 64'h100, 8'h00, 64'd0});
    we = 1'b0; f3 = 3'd3; addr = 64'h100; strb = 8'hFF; req = 1'b1;
    step();
    mready = 1'b1;
    step();
    mready = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("rsp_rst_valid", 64'(mvalid), 64'd0);
    chk("rsp_rst_done",  64'(done), 64'd0);
    chk("rsp_rst_stall", 64'(stall), 64'(req));
    chk("rsp_rst_rd",    rd, 64'd0);
    chk("rsp_rst_mq",    64'(mq.size()), 64'd0);
    step();
    req = 1'b0; rst = 1'b0;
    step(); step(); step();

    // Reset while in REQ: mem_valid_o must fall without a clock edge
    mq.push_back(mem_t'{1'b0, 64'h200, 8'h00, 64'd0});
    addr = 64'h200; req = 1'b1;
    step();
    chk("req_valid_before_rst", 64'(mvalid), 64'd1);
    #2 rst = 1'b1;
    #1 chk("req_rst_valid_async", 64'(mvalid), 64'd0);
    mq.delete();
    step();
    req = 1'b0; rst = 1'b0;
    step(); step();

    // New load after reset completes normally
    do_access(0, 0, 3'd3, 64'h108, 8'hFF, 64'd0, 0, 1, 64'h0F0F_0F0F_0F0F_0F0F,
              mem_t'{1'b0, 64'h108, 8'h00, 64'd0},
              rsp_t'{1'b0, 64'h0F0F_0F0F_0F0F_0F0F}, 3, 1, 0);
    step(); step(); step();
    chk("end_mq_empty", 64'(mq.size()), 64'd0);
    chk("end_rq_empty", 64'(rq.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
